// File: rtl/mem_stall_ctrl_if.sv
// Handshake bundle between the pipeline/SRAM side and mem_stall_ctrl.
// master: the controller; slave: pipeline, hazard unit and SRAM controller.
`timescale 1ns/1ps
interface mem_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             mem_r_en;
  logic             mem_w_en;
  logic             hazard_in;
  logic             branch_taken;
  logic             sram_ack;
  logic             stat_clr;
  logic             sram_req;
  logic             sram_we;
  logic             freeze;
  logic             id_hazard;
  logic             pc_hold;
  logic             flush;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] stall_count;

  modport master (
    input  mem_r_en, mem_w_en, hazard_in, branch_taken, sram_ack, stat_clr,
    output sram_req, sram_we, freeze, id_hazard, pc_hold, flush, busy, err, stall_count
  );

  modport slave (
    output mem_r_en, mem_w_en, hazard_in, branch_taken, sram_ack, stat_clr,
    input  sram_req, sram_we, freeze, id_hazard, pc_hold, flush, busy, err, stall_count
  );
endinterface

// File: rtl/mem_stall_ctrl.sv
// Pipeline freeze controller: runs the SRAM req/ack handshake for MEM-stage loads/stores,
// freezes the pipe while an access is outstanding and counts stall cycles.
`timescale 1ns/1ps
module mem_stall_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input logic             clk,
  input logic             rst,
  mem_stall_ctrl_if.master bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StError  = 2'd2;

  // Last un-acked ACCESS cycle before giving up.
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_op;
  logic             freeze;
  logic             pc_hold;

  assign mem_op = bus.mem_r_en | bus.mem_w_en;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    req_d   = req_q;
    we_d    = we_q;
    case (state_q)
      StIdle: begin
        if (mem_op) begin
          state_d = StAccess;
          req_d   = 1'b1;
          we_d    = bus.mem_w_en;
          tmo_d   = 8'd0;
        end
      end
      StAccess: begin
        if (bus.sram_ack) begin
          state_d = StIdle;
          req_d   = 1'b0;
          tmo_d   = 8'd0;
        end else if (tmo_q == TmoLast) begin
          state_d = StError;
          req_d   = 1'b0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StError: begin
        req_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    freeze = 1'b0;
    case (state_q)
      StIdle:   freeze = mem_op;
      // Ack cycle releases the pipe so MEM/WB captures the read data.
      StAccess: freeze = ~bus.sram_ack;
      StError:  freeze = 1'b1;
      default:  freeze = 1'b0;
    endcase
  end

  assign pc_hold = freeze | bus.hazard_in;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.stat_clr) begin
      cnt_d = '0;
    end else if (pc_hold && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      tmo_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sram_req    = req_q;
  assign bus.sram_we     = we_q;
  assign bus.freeze      = freeze;
  assign bus.id_hazard   = bus.hazard_in & ~freeze;
  assign bus.pc_hold     = pc_hold;
  assign bus.flush       = bus.branch_taken & ~freeze;
  assign bus.busy        = (state_q != StIdle);
  assign bus.err         = (state_q == StError);
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl: two instances (TIMEOUT 8/CNT_W 16 and
// TIMEOUT 4/CNT_W 4) driven with identical stimulus and compared to a cycle-level model.
`timescale 1ns/1ps
module tb_mem_stall_ctrl;

  typedef struct packed {
    logic        freeze;
    logic        req;
    logic        we;
    logic        idh;
    logic        pch;
    logic        flush;
    logic        busy;
    logic        err;
    logic [15:0] cnt;
  } out_t;

  // in = {mem_r_en, mem_w_en, hazard_in, branch_taken, sram_ack, stat_clr}
  typedef struct {
    logic [5:0]  in;
    logic        freeze;
    logic        req;
    logic        we;
    logic        busy;
    logic        idh;
    logic        pch;
    logic        flush;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic r, w, haz, br, ack, clr;

  always #5 clk = ~clk;

  mem_stall_ctrl_if #(.CNT_W(16)) ifa ();
  mem_stall_ctrl_if #(.CNT_W(4))  ifb ();

  mem_stall_ctrl #(.TIMEOUT(8), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mem_stall_ctrl #(.TIMEOUT(4), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

  assign ifa.mem_r_en = r;   assign ifb.mem_r_en = r;
  assign ifa.mem_w_en = w;   assign ifb.mem_w_en = w;
  assign ifa.hazard_in = haz; assign ifb.hazard_in = haz;
  assign ifa.branch_taken = br; assign ifb.branch_taken = br;
  assign ifa.sram_ack = ack; assign ifb.sram_ack = ack;
  assign ifa.stat_clr = clr; assign ifb.stat_clr = clr;

  out_t got_a, got_b;
  assign got_a = '{ifa.freeze, ifa.sram_req, ifa.sram_we, ifa.id_hazard, ifa.pc_hold,
                   ifa.flush, ifa.busy, ifa.err, ifa.stall_count};
  assign got_b = '{ifb.freeze, ifb.sram_req, ifb.sram_we, ifb.id_hazard, ifb.pc_hold,
                   ifb.flush, ifb.busy, ifb.err, {12'd0, ifb.stall_count}};

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: an access is "open" from its start cycle; it fails once TIMEOUT cycles
  // have elapsed without ack. ERROR keeps busy set until reset.
  int tmo  [2] = '{8, 4};
  int cmax [2] = '{65535, 15};
  int m_busy [2];
  int m_err  [2];
  int m_we   [2];
  int m_start[2];
  int m_cnt  [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_err[k] = 0; m_we[k] = 0; m_start[k] = 0; m_cnt[k] = 0;
    end
  endfunction

  function automatic out_t model_out(int k);
    out_t o;
    o.busy   = (m_busy[k] != 0);
    o.err    = (m_err[k] != 0);
    o.req    = (m_busy[k] != 0) && (m_err[k] == 0);
    o.we     = (m_we[k] != 0);
    if (m_err[k] != 0)       o.freeze = 1'b1;
    else if (m_busy[k] != 0) o.freeze = ~ack;
    else                     o.freeze = r | w;
    o.idh    = haz & ~o.freeze;
    o.pch    = haz | o.freeze;
    o.flush  = br & ~o.freeze;
    o.cnt    = 16'(m_cnt[k]);
    return o;
  endfunction

  function automatic void model_edge(int k);
    out_t o = model_out(k);
    if (m_busy[k] == 0) begin
      if (r || w) begin
        m_busy[k] = 1; m_start[k] = cyc + 1; m_we[k] = int'(w);
      end
    end else if (m_err[k] == 0) begin
      if (ack) m_busy[k] = 0;
      else if (cyc - m_start[k] + 1 >= tmo[k]) m_err[k] = 1;
    end
    if (clr) m_cnt[k] = 0;
    else if (o.pch && m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
  endfunction

  function automatic void chk_out(string name, out_t g, out_t e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, g, e);
    end
  endfunction

  function automatic void chk_val(string name, int g, int e);
    checks++;
    if (g != e) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, g, e);
    end
  endfunction

  task automatic sample(input logic [5:0] in);
    {r, w, haz, br, ack, clr} = in;
    @(negedge clk);
    chk_out("model_a", got_a, model_out(0));
    chk_out("model_b", got_b, model_out(1));
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    cyc++;
    #1;
  endtask

  task automatic step(input logic [5:0] in);
    sample(in);
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    {r, w, haz, br, ack, clr} = 6'($urandom);
    #2;
    chk_val("rst_req_a", int'(ifa.sram_req), 0);
    chk_val("rst_busy_a", int'(ifa.busy), 0);
    chk_val("rst_err_b", int'(ifb.err), 0);
    chk_val("rst_busy_b", int'(ifb.busy), 0);
    @(posedge clk);
    #1;
    chk_val("rst_cnt_a", int'(ifa.stall_count), 0);
    chk_val("rst_cnt_b", int'(ifb.stall_count), 0);
    chk_val("rst_req_b", int'(ifb.sram_req), 0);
    {r, w, haz, br, ack, clr} = 6'd0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  vec_t vecs[17];

  initial begin
    rst = 1'b0;
    {r, w, haz, br, ack, clr} = 6'd0;
    model_reset();

    // Load ack after 5, store+load back-to-back, hazard/branch during freeze.
    vecs[0]  = '{6'b100000, 1, 0, 0, 0, 0, 1, 0, 16'd0};
    vecs[1]  = '{6'b100000, 1, 1, 0, 1, 0, 1, 0, 16'd1};
    vecs[2]  = '{6'b100000, 1, 1, 0, 1, 0, 1, 0, 16'd2};
    vecs[3]  = '{6'b100000, 1, 1, 0, 1, 0, 1, 0, 16'd3};
    vecs[4]  = '{6'b100000, 1, 1, 0, 1, 0, 1, 0, 16'd4};
    vecs[5]  = '{6'b100010, 0, 1, 0, 1, 0, 0, 0, 16'd5};
    vecs[6]  = '{6'b000000, 0, 0, 0, 0, 0, 0, 0, 16'd5};
    vecs[7]  = '{6'b010000, 1, 0, 0, 0, 0, 1, 0, 16'd5};
    vecs[8]  = '{6'b010010, 0, 1, 1, 1, 0, 0, 0, 16'd6};
    vecs[9]  = '{6'b100000, 1, 0, 1, 0, 0, 1, 0, 16'd6};
    vecs[10] = '{6'b100010, 0, 1, 0, 1, 0, 0, 0, 16'd7};
    vecs[11] = '{6'b000000, 0, 0, 0, 0, 0, 0, 0, 16'd7};
    vecs[12] = '{6'b100000, 1, 0, 0, 0, 0, 1, 0, 16'd7};
    vecs[13] = '{6'b101100, 1, 1, 0, 1, 0, 1, 0, 16'd8};
    vecs[14] = '{6'b101010, 0, 1, 0, 1, 1, 1, 0, 16'd9};
    vecs[15] = '{6'b001000, 0, 0, 0, 0, 1, 1, 0, 16'd10};
    vecs[16] = '{6'b000000, 0, 0, 0, 0, 0, 0, 0, 16'd11};

    do_reset();
    step(6'd0);

    for (int i = 0; i < 17; i++) begin
      out_t e;
      sample(vecs[i].in);
      e = '{vecs[i].freeze, vecs[i].req, vecs[i].we, vecs[i].idh, vecs[i].pch,
            vecs[i].flush, vecs[i].busy, 1'b0, vecs[i].cnt};
      chk_out($sformatf("vec%0d", i), got_a, e);
      advance();
    end

    // Timeout on dut_b (TIMEOUT=4): op at T, ERROR at T+5, late ack ignored.
    do_reset();
    for (int i = 0; i < 5; i++) step(6'b100000);
    sample(6'b100010);
    chk_val("tmo_err", int'(ifb.err), 1);
    chk_val("tmo_freeze", int'(ifb.freeze), 1);
    chk_val("tmo_req", int'(ifb.sram_req), 0);
    advance();
    step(6'b000010);
    sample(6'b000000);
    chk_val("tmo_err_hold", int'(ifb.err), 1);
    chk_val("tmo_freeze_hold", int'(ifb.freeze), 1);
    advance();
    // Reset in the middle of an access on dut_a.
    step(6'b100000);
    step(6'b100000);
    do_reset();
    chk_val("post_rst_err_b", int'(ifb.err), 0);

    // Counter saturation on dut_b, then clear with pc_hold still high.
    for (int i = 0; i < 20; i++) step(6'b001000);
    sample(6'b001001);
    chk_val("cnt_sat_b", int'(ifb.stall_count), 15);
    chk_val("cnt_a_20", int'(ifa.stall_count), 20);
    advance();
    sample(6'b001000);
    chk_val("cnt_clr_b", int'(ifb.stall_count), 0);
    advance();

    // Randomized stimulus against the model.
    for (int round = 0; round < 8; round++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        logic [5:0] in;
        in[5] = ($urandom_range(0, 3) == 0);
        in[4] = ($urandom_range(0, 3) == 0);
        in[3] = ($urandom_range(0, 9) < 3);
        in[2] = ($urandom_range(0, 9) < 3);
        in[1] = ($urandom_range(0, 9) < (round < 4 ? 4 : 2));
        in[0] = ($urandom_range(0, 29) == 0);
        step(in);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
